// File: rtl/uart_rx_fifo_pkg.sv
// Shared configuration macros and types for the UART receive FIFO.
// Optional overflow counter is enabled by defining UART_RX_FIFO_OVF_CNT_EN.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef RX_FIFO_DEPTH
`define RX_FIFO_DEPTH 8
`endif

package uart_rx_fifo_pkg;

  localparam int OVF_CNT_W = 8;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    return fifo_op_e'({rd, wr});
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read at i_rd_addr.
// Contents are intentionally not reset.
module rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic w_sel;
      assign w_sel = i_wr_en && (i_wr_addr == ADDR_W'(gi));
      always_ff @(posedge CLK) begin
        if (w_sel) begin
          r_mem[gi] <= i_wr_data;
        end
      end
    end
  endgenerate

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART Rx FSM: one push per Data_Valid rising edge,
// registered pop, sticky overflow. Define UART_RX_FIFO_OVF_CNT_EN to add OVF_CNT.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = `WIDTH,
  parameter int DEPTH      = `RX_FIFO_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_W:0]       COUNT,
  output logic                  OVF,
  input  logic                  OVF_CLR
`ifdef UART_RX_FIFO_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]  OVF_CNT
`endif
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic                  r_dv_q;
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_ovf;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_drop;
  logic                  w_mem_we;
  logic [ADDR_W:0]       w_count_next;
  logic [DATA_WIDTH-1:0] w_mem_rd;

  assign w_push   = Data_Valid & ~r_dv_q;
  assign w_pop    = RD_EN & ~r_empty;
  // A pop in the same cycle frees the slot, so a push on a full buffer still lands.
  assign w_wr     = w_push & (~r_full | w_pop);
  assign w_drop   = w_push & r_full & ~w_pop;
  assign w_mem_we = w_wr & RST;

  always_comb begin
    w_count_next = r_count;
    case (fifo_op(w_wr, w_pop))
      OP_PUSH: w_count_next = r_count + CNT_ONE;
      OP_POP:  w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .CLK       (CLK),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (P_DATA),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_dv_q     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_dv_q     <= Data_Valid;
      r_rd_valid <= w_pop;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_rd_data <= w_mem_rd;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_FULL);
      r_empty <= (w_count_next == CNT_ZERO);
      // A fresh overflow beats a simultaneous clear.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (OVF_CLR) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_ovf_cnt <= '0;
    end else if (OVF_CLR) begin
      r_ovf_cnt <= w_drop ? OVF_CNT_W'(1) : '0;
    end else if (w_drop && !(&r_ovf_cnt)) begin
      r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
    end
  end

  assign OVF_CNT = r_ovf_cnt;
`endif

  assign RD_DATA  = r_rd_data;
  assign RD_VALID = r_rd_valid;
  assign FULL     = r_full;
  assign EMPTY    = r_empty;
  assign COUNT    = r_count;
  assign OVF      = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          RD_EN = 1'b0;
  logic          OVF_CLR = 1'b0;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   COUNT;
  logic          OVF;
`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0]    OVF_CNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .RD_EN      (RD_EN),
    .RD_DATA    (RD_DATA),
    .RD_VALID   (RD_VALID),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .COUNT      (COUNT),
    .OVF        (OVF),
    .OVF_CLR    (OVF_CLR)
`ifdef UART_RX_FIFO_OVF_CNT_EN
    ,
    .OVF_CNT    (OVF_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored bytes, updated once per rising edge.
  logic [DW-1:0] m_q[$];
  logic          m_dv_prev  = 1'b0;
  logic          m_ovf      = 1'b0;
  logic          m_rd_valid = 1'b0;
  logic [DW-1:0] m_rd_data  = '0;
  int            m_ovf_cnt  = 0;
  bit            m_ready    = 1'b0;
  bit            m_push, m_pop, m_drop;

  initial begin
    forever begin
      @(posedge CLK);
      if (!RST) begin
        m_q.delete();
        m_dv_prev  = 1'b0;
        m_ovf      = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
        m_ovf_cnt  = 0;
      end else begin
        m_push = Data_Valid && !m_dv_prev;
        m_pop  = RD_EN && (m_q.size() > 0);
        m_drop = m_push && (m_q.size() == DEPTH) && !m_pop;
        m_rd_valid = m_pop;
        if (m_pop) m_rd_data = m_q.pop_front();
        if (m_push && !m_drop) m_q.push_back(P_DATA);
        if (m_drop) m_ovf = 1'b1;
        else if (OVF_CLR) m_ovf = 1'b0;
        if (OVF_CLR) m_ovf_cnt = m_drop ? 1 : 0;
        else if (m_drop && m_ovf_cnt < 255) m_ovf_cnt++;
        m_dv_prev = Data_Valid;
      end
      m_ready = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (m_ready) begin
        check("m_count",    COUNT,    m_q.size());
        check("m_empty",    EMPTY,    m_q.size() == 0);
        check("m_full",     FULL,     m_q.size() == DEPTH);
        check("m_ovf",      OVF,      m_ovf);
        check("m_rd_valid", RD_VALID, m_rd_valid);
        check("m_rd_data",  RD_DATA,  m_rd_data);
`ifdef UART_RX_FIFO_OVF_CNT_EN
        check("m_ovf_cnt",  OVF_CNT,  m_ovf_cnt);
`endif
      end
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic frame(input logic [DW-1:0] b, input int hold);
    P_DATA     = b;
    Data_Valid = 1'b1;
    repeat (hold) @(negedge CLK);
    Data_Valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pop_expect(input string name, input logic [DW-1:0] exp);
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
    check({name, "_valid"}, RD_VALID, 1);
    check(name, RD_DATA, exp);
  endtask

  initial begin
    // Reset with Data_Valid high, then release while it stays high.
    RST        = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'h3C;
    repeat (2) @(negedge CLK);
    check("rst_empty",    EMPTY,    1);
    check("rst_count",    COUNT,    0);
    check("rst_rd_valid", RD_VALID, 0);
    check("rst_ovf",      OVF,      0);
    check("rst_full",     FULL,     0);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_release_push", COUNT, 1);
    repeat (4) @(negedge CLK);
    check("rst_release_once", COUNT, 1);
    Data_Valid = 1'b0;
    @(negedge CLK);
    pop_expect("rst_byte", 8'h3C);

    // Single frame with a long Data_Valid level.
    frame(8'hA5, 20);
    check("single_count", COUNT, 1);
    pop_expect("single_byte", 8'hA5);
    @(negedge CLK);
    check("single_rv_drop", RD_VALID, 0);
    check("single_empty",   EMPTY,    1);

    // Fill, overflow, drain, clear.
    for (int i = 1; i <= 8; i++) frame(8'(i), 1);
    check("fill_full", FULL, 1);
    check("fill_ovf0", OVF,  0);
    frame(8'h09, 1);
    check("ovf_full",  FULL,  1);
    check("ovf_set",   OVF,   1);
    check("ovf_count", COUNT, 8);
    for (int i = 1; i <= 8; i++) pop_expect("drain_byte", 8'(i));
    check("drain_empty", EMPTY, 1);
    check("ovf_sticky",  OVF,   1);
    OVF_CLR = 1'b1;
    @(negedge CLK);
    OVF_CLR = 1'b0;
    check("ovf_clr", OVF, 0);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) frame(8'h20 + 8'(i), 1);
    P_DATA     = 8'h55;
    Data_Valid = 1'b1;
    RD_EN      = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    RD_EN      = 1'b0;
    check("both_rv",    RD_VALID, 1);
    check("both_data",  RD_DATA,  8'h20);
    check("both_count", COUNT,    8);
    check("both_ovf",   OVF,      0);
    check("both_full",  FULL,     1);
    @(negedge CLK);
    for (int i = 1; i < 8; i++) pop_expect("both_drain", 8'h20 + 8'(i));
    pop_expect("both_last", 8'h55);

    // Pointer wrap.
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 5; k++) frame(8'h10 + 8'(it * 5 + k), 1);
      for (int k = 0; k < 5; k++) pop_expect("wrap_byte", 8'h10 + 8'(it * 5 + k));
    end
    check("wrap_empty", EMPTY, 1);

    // Read while empty is ignored.
    RD_EN = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("empty_rd_rv",    RD_VALID, 0);
      check("empty_rd_count", COUNT,    0);
      check("empty_rd_data",  RD_DATA,  8'h1E);
    end
    RD_EN = 1'b0;

    // Overflow and clear in the same cycle: set wins.
    for (int i = 0; i < 8; i++) frame(8'h40 + 8'(i), 1);
    P_DATA     = 8'hEE;
    Data_Valid = 1'b1;
    OVF_CLR    = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    OVF_CLR    = 1'b0;
    check("set_wins_ovf",   OVF,   1);
    check("set_wins_count", COUNT, 8);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    check("set_wins_cnt", OVF_CNT, 1);
    @(negedge CLK);
    for (int i = 0; i < 300; i++) frame(8'hEE, 1);
    check("ovf_cnt_sat", OVF_CNT, 255);
    OVF_CLR = 1'b1;
    @(negedge CLK);
    OVF_CLR = 1'b0;
    check("ovf_cnt_clr", OVF_CNT, 0);
    check("ovf_cnt_ovf", OVF,     0);
`else
    @(negedge CLK);
`endif
    pop_expect("final_byte", 8'h40);
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART Rx frame FSM and deserializer.
- Captures each good frame's parallel byte when the Rx FSM's Data_Valid rises.
- Stores bytes in a power-of-two circular buffer and hands them to the host through a registered read handshake.
- Flags bytes dropped on a full buffer with a sticky overflow indication.

Parameters:
- DATA_WIDTH, default `WIDTH (8): frame payload width; must match the deserializer's P_DATA.
- DEPTH, default 8: number of entries; power of two, at least 2.
- ADDR_W, default $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- CLK  in  1  system clock, same domain as the Rx FSM.
- RST  in  1  reset, synchronous, active-low.
- P_DATA  in  DATA_WIDTH  deserialized byte from the Rx datapath.
- Data_Valid  in  1  Rx FSM level flag; high from end of a good STOP until the next START.
- RD_EN  in  1  host pop request, one byte per cycle.
- RD_DATA  out  DATA_WIDTH  popped byte, registered.
- RD_VALID  out  1  one-cycle strobe qualifying RD_DATA.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  ADDR_W+1  current occupancy.
- OVF  out  1  sticky overflow flag.
- OVF_CLR  in  1  clears OVF.

Behaviour:
- Reset (RST low at a CLK edge): pointers=0, COUNT=0, EMPTY=1, FULL=0, RD_DATA=0, RD_VALID=0, OVF=0, dv_q=0. Memory contents are not reset. Reset overrides every other event in the same cycle.
- Push detect:
  - dv_q is Data_Valid registered each cycle.
  - push = Data_Valid & ~dv_q. This gives exactly one push per frame, because Data_Valid stays high for many cycles.
  - P_DATA is sampled in the push cycle.
- Write:
  - If push and (!FULL or pop), write mem[wr_ptr] <= P_DATA and increment wr_ptr, wrapping modulo DEPTH.
- Pop:
  - pop = RD_EN & !EMPTY. On pop, RD_DATA <= mem[rd_ptr], increment rd_ptr with wrap, and set RD_VALID=1 on the next cycle.
  - Read latency is 1 cycle from RD_EN to RD_VALID.
  - RD_DATA holds its last value when no pop occurs. RD_VALID=0 on every cycle without a pop.
  - RD_EN while EMPTY is ignored; there is no fall-through. A push and RD_EN in the same cycle on an empty buffer gives push only, and COUNT becomes 1.
- COUNT next:
  - +1 on push-only.
  - -1 on pop-only.
  - Unchanged on simultaneous push and pop, including when full. When full, the pop frees a slot and the push is accepted.
- FULL and EMPTY are registered, derived from the next COUNT, and valid in the same cycle as COUNT.
- Overflow:
  - A push while FULL with no pop drops the byte. Pointers and COUNT are unchanged, and OVF <= 1.
  - OVF stays set until OVF_CLR=1.
  - If a new overflow and OVF_CLR occur in the same cycle, set wins.
- Pointer wrap: wr_ptr and rd_ptr are ADDR_W bits and wrap naturally. Full versus empty is resolved by COUNT, not by pointer compare.
- This block does not inspect Rx frame errors. Frames with parity or stop errors never raise Data_Valid.

Optional Feature:
- Macro: UART_RX_FIFO_OVF_CNT_EN.
- Defined:
  - Adds output OVF_CNT [7:0], reset 0.
  - Increments by 1 per dropped byte and saturates at 255.
  - Cleared by OVF_CLR. An increment in the same cycle as the clear loads 1.
- Undefined: port and counter are absent. OVF behaviour is identical in both builds.

Decomposition:
- Shared CONFIG_MACROS include:
  - `WIDTH is reused for DATA_WIDTH.
  - Add `RX_FIFO_DEPTH (8) and the overflow counter width constant OVF_CNT_W (8).
- Sub-module: rx_fifo_mem, a simple dual-port register array with a synchronous write port and a read port indexed by rd_ptr.
- Pointer, count, push-edge and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset: drive RST=0 for 2 cycles with Data_Valid=1 → EMPTY=1, COUNT=0, RD_VALID=0, OVF=0. Release RST while Data_Valid=1 → exactly one push.
- Single frame: P_DATA=0xA5 with Data_Valid held high 20 cycles → COUNT=1 (one push only). RD_EN pulse → RD_VALID one cycle later with RD_DATA=0xA5, then EMPTY=1.
- Fill and overflow (DEPTH=8): push 0x01..0x08, then push 0x09 → FULL=1, OVF=1, COUNT=8, 0x09 dropped. Pop 8 times → 0x01..0x08 in order. OVF_CLR → OVF=0.
- Simultaneous push and pop at full: 8 entries stored, push 0x55 together with RD_EN → COUNT stays 8, OVF=0, oldest byte is returned, and 0x55 is read last.
- Wrap: 3 iterations of push 5 / pop 5 with values 0x10+i → pointers wrap, data order preserved, EMPTY=1 at the end.
- Empty read: RD_EN=1 with EMPTY=1 for 3 cycles → RD_VALID=0, COUNT=0, RD_DATA unchanged. With the macro defined, 300 overflow pushes → OVF_CNT=255.
